// File: rtl/boton_acondicionador_if.sv
// Button conditioner bundle: raw pins in; debounced level, press pulse and long-press pulse out.
interface boton_acondicionador_if #(
   parameter int unsigned N_BTN = 2
);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_estable;
   logic [N_BTN-1:0] btn_pulso;
   logic [N_BTN-1:0] btn_largo;

   modport master (
      output btn_raw,
      input  btn_estable,
      input  btn_pulso,
      input  btn_largo
   );

   modport slave (
      input  btn_raw,
      output btn_estable,
      output btn_pulso,
      output btn_largo
   );
endinterface

// File: rtl/boton_acondicionador.sv
// Push-button front end: 2-FF synchroniser, debounce, press pulse per channel.
// Define HOLD_DETECT_EN to add the per-channel long-press pulse on btn_largo.
module boton_acondicionador #(
   parameter int unsigned N_BTN       = 2,
   parameter int unsigned DEB_CYCLES  = 16,
   parameter int unsigned HOLD_CYCLES = 64,
   parameter bit          ACTIVO_BAJO = 1'b0
) (
   input logic                   clk,
   input logic                   reset,
   boton_acondicionador_if.slave bus
);
   localparam int unsigned     DebW    = $clog2(DEB_CYCLES + 1);
   localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

   if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("DEB_CYCLES must be at least 2");
   end
   if (HOLD_CYCLES <= DEB_CYCLES) begin : g_bad_hold
      $error("HOLD_CYCLES must exceed DEB_CYCLES");
   end

   logic [N_BTN-1:0] raw_pressed;
   assign raw_pressed = bus.btn_raw ^ {N_BTN{ACTIVO_BAJO}};

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic            sync1_q, sync1_d;
      logic            sync2_q, sync2_d;
      logic            estable_q, estable_d;
      logic            pulso_q, pulso_d;
      logic [DebW-1:0] deb_cnt_q, deb_cnt_d;

      // Any sample matching the accepted level restarts the count, so bounces never accumulate.
      always_comb begin
         sync1_d   = raw_pressed[i];
         sync2_d   = sync1_q;
         estable_d = estable_q;
         pulso_d   = 1'b0;
         deb_cnt_d = '0;
         if (sync2_q != estable_q) begin
            if (deb_cnt_q == DebLast) begin
               estable_d = sync2_q;
               pulso_d   = sync2_q;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            estable_q <= 1'b0;
            pulso_q   <= 1'b0;
            deb_cnt_q <= '0;
         end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            estable_q <= estable_d;
            pulso_q   <= pulso_d;
            deb_cnt_q <= deb_cnt_d;
         end
      end

      assign bus.btn_estable[i] = estable_q;
      assign bus.btn_pulso[i]   = pulso_q;

`ifdef HOLD_DETECT_EN
      localparam int unsigned      HoldW    = $clog2(HOLD_CYCLES + 1);
      localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES);
      localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

      logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
      logic             largo_q, largo_d;

      // Saturation keeps the HoldLast match to a single cycle per press.
      always_comb begin
         hold_cnt_d = '0;
         largo_d    = 1'b0;
         if (estable_q) begin
            hold_cnt_d = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + 1'b1;
            largo_d    = (hold_cnt_q == HoldLast);
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            hold_cnt_q <= '0;
            largo_q    <= 1'b0;
         end else begin
            hold_cnt_q <= hold_cnt_d;
            largo_q    <= largo_d;
         end
      end

      assign bus.btn_largo[i] = largo_q;
`else
      assign bus.btn_largo[i] = 1'b0;
`endif
   end
endmodule
